// File: rtl/tag_stream_loader_pkg.sv
// Shared types and defaults for the tag stream loader: widths, state encoding
// and the bit-counter width helper.
package tag_loader_pkg;

    localparam int TAG_W_DEF     = 8;
    localparam int EVAL_WAIT_DEF = 1;
    localparam int WAIT_W        = 4;
    localparam int CNT_W_DEF     = $clog2(TAG_W_DEF + 1);

    typedef enum logic {
        SHIFT = 1'b0,
        EVAL  = 1'b1
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/tag_stream_loader_if.sv
// Serial-in / result-out handshake bundle. Both sides use valid/ready: a
// transfer happens on a rising edge where valid and ready are both high; the
// source holds its payload stable until then.
interface tag_stream_loader_if
    import tag_loader_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
);
    logic             s_valid;
    logic             s_ready;
    logic             s_bit;
    logic             s_first;
    logic             m_valid;
    logic             m_ready;
    logic [TAG_W-1:0] m_tag;
    logic             m_result;

    modport master (
        output s_valid, s_bit, s_first, m_ready,
        input  s_ready, m_valid, m_tag, m_result
    );

    modport slave (
        input  s_valid, s_bit, s_first, m_ready,
        output s_ready, m_valid, m_tag, m_result
    );
endinterface

// File: rtl/tag_stream_loader_deser.sv
// MSB-first deserialiser: shifts accepted bits, tracks the frame position and
// strobes word_done on the bit that completes a TAG_W-bit word.
module tag_deser
    import tag_loader_pkg::*;
#(
    parameter  int TAG_W = TAG_W_DEF,
    localparam int CW    = cnt_w(TAG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             s_bit,
    input  logic             s_first,
    output logic [CW-1:0]    bit_cnt,
    output logic             word_done,
    output logic [TAG_W-1:0] word,
    output logic             frame_err
);
    // Only TAG_W-1 history bits are kept; the incoming bit completes the word.
    logic [TAG_W-2:0] shreg;

    assign word      = {shreg, s_bit};
    assign word_done = accept && !s_first && (bit_cnt == CW'(TAG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && s_first && (bit_cnt != '0);
            if (accept) begin
                shreg <= word[TAG_W-2:0];
                if (s_first) begin
                    bit_cnt <= CW'(1);
                end else if (word_done) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tag_stream_loader.sv
// Front end of the tag evaluator: holds each deserialised word on tag_o, waits
// EVAL_WAIT cycles for the verdict to settle, then offers {tag, verdict}.
module tag_stream_loader
    import tag_loader_pkg::*;
#(
    parameter int TAG_W     = TAG_W_DEF,
    parameter int EVAL_WAIT = EVAL_WAIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    tag_stream_loader_if.slave   bus,
    output logic [TAG_W-1:0]     tag_o,
    input  logic                 chk_i,
    output logic                 frame_err,
    output state_t               dbg_state
);
    localparam int CW = cnt_w(TAG_W);

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CW-1:0]      bit_cnt;
    logic               accept;
    logic               word_done;
    logic               sample;
    logic [TAG_W-1:0]   word;

    // The completing bit waits while an unread result still occupies the slot.
    assign bus.s_ready = !rst && (state == SHIFT) &&
                         !((bit_cnt == CW'(TAG_W - 1)) && bus.m_valid && !bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready;
    assign dbg_state   = state;

    tag_deser #(.TAG_W(TAG_W)) u_deser (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .s_bit     (bus.s_bit),
        .s_first   (bus.s_first),
        .bit_cnt   (bit_cnt),
        .word_done (word_done),
        .word      (word),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHIFT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        case (state)
            SHIFT: if (word_done) state_nxt = EVAL;
            EVAL: begin
                if (wait_cnt == WAIT_W'(EVAL_WAIT - 1)) begin
                    sample    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_o        <= '0;
            wait_cnt     <= '0;
            bus.m_valid  <= 1'b0;
            bus.m_tag    <= '0;
            bus.m_result <= 1'b0;
        end else begin
            if (word_done) begin
                tag_o    <= word;
                wait_cnt <= '0;
            end else if (state == EVAL) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            // The slot is guaranteed empty at sample time, so no result is overwritten.
            if (sample) begin
                bus.m_valid  <= 1'b1;
                bus.m_tag    <= tag_o;
                bus.m_result <= chk_i;
            end else if (bus.m_valid && bus.m_ready) begin
                bus.m_valid  <= 1'b0;
            end
        end
    end

endmodule
